shift_deserializer: RTL and testbench
=====================================

Name: shift_deserializer

Overview:
- Receive end of the serial link driven by our universal shift-register cells: collects a framed serial bit stream into a WIDTH-bit parallel word.
- Bit order is selectable per frame to match left-shift (MSB-first) or right-shift (LSB-first) transmitters.
- A one-word output register with a valid/ready handshake decouples the word from the consumer; dropped words are flagged.

Parameters:
- WIDTH, 8, parallel word width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  frame start pulse; arms or re-arms capture.
- dir  input  1  bit order, sampled with start: 0 = MSB-first (shift left), 1 = LSB-first (shift right).
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a valid bit this cycle.
- pdata_out  output  WIDTH  assembled parallel word.
- pvalid  output  1  pdata_out holds an unconsumed word.
- pready  input  1  consumer accepts pdata_out when pvalid=1.
- busy  output  1  frame capture in progress.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, shift register=0, bit count=0, pdata_out=0, pvalid=0, busy=0, overrun=0. Reset overrides every other input, including mid-frame; the partial frame is discarded.
- FSM states: IDLE, SHIFT.
  - IDLE: sin and sin_valid are ignored. start=1 -> SHIFT; latch dir; clear shift register and count.
  - SHIFT: busy=1 (registered; goes high the cycle after start).
- Shift rules in SHIFT, on each edge with sin_valid=1:
  - dir=0: sreg <= {sreg[WIDTH-2:0], sin}. The first bit ends in the MSB.
  - dir=1: sreg <= {sin, sreg[WIDTH-1:1]}. The first bit ends in the LSB.
  - count increments.
  - sin_valid=0: sreg and count hold. Stalls of any length are legal.
- Completion: on the edge where sin_valid=1 and count=WIDTH-1:
  - the shifted value including that bit goes to the output register;
  - FSM -> IDLE, busy -> 0, count -> 0.
  - Latency: pvalid is high in the cycle after the last bit's edge.
- start while in SHIFT: abort and restart. Clear sreg and count, re-latch dir, stay in SHIFT, produce no output. start has priority over sin_valid in that cycle; that bit is not captured.
- Output handshake (pvalid, pready):
  - Consume on an edge with pvalid=1 and pready=1.
  - Consume with no completion: pvalid -> 0 and pdata_out holds its value.
  - pready while pvalid=0 has no effect.
  - pdata_out is stable while pvalid=1 and not consumed.
- Completion vs. output register state:
  - pvalid=0: load the word, pvalid -> 1.
  - pvalid=1 and pready=1 in the same cycle: old word consumed, new word loaded, pvalid stays 1, no overrun.
  - pvalid=1 and pready=0: new word dropped, pdata_out unchanged, overrun -> 1.
- overrun is sticky and clears only on reset.
- The count is wide enough for WIDTH-1 (clog2) and never wraps past WIDTH-1.

Test Plan:
- WIDTH=8, pready=1. start with dir=0, then sin 1,0,1,1,0,0,1,0 on 8 consecutive sin_valid cycles -> pdata_out=8'hB2; pvalid high for exactly one cycle after the 8th edge; busy 1 during the frame, 0 after.
- Same bits with dir=1 -> pdata_out=8'h4D.
- Same bits as the dir=0 case, with sin_valid=0 gaps of 1-3 cycles inserted between bits -> pdata_out=8'hB2; busy stays 1 through the gaps.
- pready=0: frame 8'hB2, then frame 8'h4D -> pdata_out stays 8'hB2, overrun=1. After reset, hold pvalid pending and assert pready on the completion edge of the next frame -> new word loaded, pvalid stays 1, overrun=0.
- start, 3 bits, start again, then bits giving 8'h5A -> pdata_out=8'h5A; no word emitted for the aborted frame.
- rst_n=0 for one cycle after 4 bits -> all outputs 0, FSM in IDLE. A following full frame of 8'hC3 -> pdata_out=8'hC3.

Source files
------------

// File: rtl/shift_deserializer_if.sv
// rtl/shift_deserializer_if.sv - bundles the serial input, framing controls and parallel output handshake
//
// Signals:
//   start      frame start pulse (arms or re-arms capture)
//   dir        bit order, sampled with start: 0 = MSB-first, 1 = LSB-first
//   sin        serial data bit
//   sin_valid  sin carries a valid bit this cycle
//   pdata_out  assembled parallel word
//   pvalid     pdata_out holds an unconsumed word
//   pready     consumer accepts pdata_out when pvalid=1
//   busy       frame capture in progress
//   overrun    sticky flag: a completed word was dropped
// Modports: master = link driver / consumer side, slave = deserializer side.
interface shift_deserializer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             dir;
   logic             sin;
   logic             sin_valid;
   logic [WIDTH-1:0] pdata_out;
   logic             pvalid;
   logic             pready;
   logic             busy;
   logic             overrun;

   modport master (
      output start, dir, sin, sin_valid, pready,
      input  pdata_out, pvalid, busy, overrun
   );

   modport slave (
      input  start, dir, sin, sin_valid, pready,
      output pdata_out, pvalid, busy, overrun
   );
endinterface

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - collects a framed serial bit stream into a WIDTH-bit word with valid/ready output
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    shift_deserializer_if.slave: start/dir/sin/sin_valid in,
//          pdata_out/pvalid out with pready in, busy and sticky overrun out
module shift_deserializer #(
   parameter int WIDTH = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   shift_deserializer_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q;
   logic             dir_q;
   logic [WIDTH-1:0] sreg_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] pdata_q;
   logic             pvalid_q;
   logic             busy_q;
   logic             overrun_q;

   logic [WIDTH-1:0] sreg_d;
   logic             last_bit;
   logic             consume;
   logic             can_load;

   // Shifted value including the current bit; used both for the running
   // register and for the word handed to the output on the final bit.
   always_comb begin
      sreg_d = sreg_q;
      if (dir_q) begin
         sreg_d = {bus.sin, sreg_q[WIDTH-1:1]};
      end else begin
         sreg_d = {sreg_q[WIDTH-2:0], bus.sin};
      end
   end

   assign last_bit = (count_q == LAST_CNT);
   assign consume  = pvalid_q & bus.pready;
   // The output register can take a new word if empty or being emptied now.
   assign can_load = ~pvalid_q | bus.pready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         dir_q     <= 1'b0;
         sreg_q    <= '0;
         count_q   <= '0;
         pdata_q   <= '0;
         pvalid_q  <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         // A completion below may re-assert pvalid in the same cycle.
         if (consume) begin
            pvalid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q <= SHIFT;
                  busy_q  <= 1'b1;
                  dir_q   <= bus.dir;
                  sreg_q  <= '0;
                  count_q <= '0;
               end
            end

            SHIFT: begin
               if (bus.start) begin
                  // Abort and re-arm; the bit presented this cycle is dropped.
                  dir_q   <= bus.dir;
                  sreg_q  <= '0;
                  count_q <= '0;
               end else if (bus.sin_valid) begin
                  sreg_q <= sreg_d;
                  if (last_bit) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     count_q <= '0;
                     if (can_load) begin
                        pdata_q  <= sreg_d;
                        pvalid_q <= 1'b1;
                     end else begin
                        overrun_q <= 1'b1;
                     end
                  end else begin
                     count_q <= count_q + CW'(1);
                  end
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pdata_out = pdata_q;
   assign bus.pvalid    = pvalid_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - self-checking bench for shift_deserializer with a queue-based reference model
module tb_shift_deserializer;

   localparam int W = 8;

   logic clk;
   logic rst_n;

   shift_deserializer_if #(.WIDTH(W)) bus ();

   shift_deserializer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   bit         m_active;
   bit         m_dir;
   bit         m_bits[$];
   logic [W-1:0] m_pdata;
   bit         m_pvalid;
   bit         m_overrun;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Word value from the bit sequence as received, following the bit-order rule.
   function automatic logic [W-1:0] assemble(input bit d);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (d) w[i] = m_bits[i];
         else   w[W-1-i] = m_bits[i];
      end
      return w;
   endfunction

   task automatic model_edge(input bit r, input bit st, input bit d, input bit s,
                             input bit sv, input bit pr);
      bit           comp;
      bit           old_pv;
      logic [W-1:0] word;
      comp = 0;
      word = '0;
      if (!r) begin
         m_active = 0; m_dir = 0; m_bits.delete();
         m_pdata = '0; m_pvalid = 0; m_overrun = 0;
         return;
      end
      old_pv = m_pvalid;
      if (st) begin
         m_active = 1; m_dir = d; m_bits.delete();
      end else if (m_active && sv) begin
         m_bits.push_back(s);
         if (m_bits.size() == W) begin
            word = assemble(m_dir);
            comp = 1;
            m_active = 0;
            m_bits.delete();
         end
      end
      if (old_pv && pr) m_pvalid = 0;
      if (comp) begin
         if (!old_pv || pr) begin
            m_pdata = word; m_pvalid = 1;
         end else begin
            m_overrun = 1;
         end
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare just after it.
   task automatic step(input bit r, input bit st, input bit d, input bit s,
                       input bit sv, input bit pr);
      rst_n         = r;
      bus.start     = st;
      bus.dir       = d;
      bus.sin       = s;
      bus.sin_valid = sv;
      bus.pready    = pr;
      @(posedge clk);
      model_edge(r, st, d, s, sv, pr);
      #1;
      check("pdata",   32'(bus.pdata_out), 32'(m_pdata));
      check("pvalid",  32'(bus.pvalid),    32'(m_pvalid));
      check("busy",    32'(bus.busy),      32'(m_active));
      check("overrun", 32'(bus.overrun),   32'(m_overrun));
   endtask

   task automatic idle(input int n, input bit pr);
      for (int i = 0; i < n; i++) step(1, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), pr);
   endtask

   // seq[W-1] is the first bit on the wire. pr_last applies on the final bit edge.
   task automatic send_frame(input logic [W-1:0] seq, input bit d, input int maxgap,
                             input bit pr, input bit pr_last);
      step(1, 1, d, 0, 0, pr);
      check("busy_after_start", 32'(bus.busy), 32'd1);
      for (int i = W - 1; i >= 0; i--) begin
         int g;
         g = (maxgap > 0) ? $urandom_range(1, maxgap) : 0;
         if (i == W - 1) g = 0;
         for (int k = 0; k < g; k++) begin
            step(1, 0, 0, $urandom_range(0, 1), 0, pr);
            check("busy_gap", 32'(bus.busy), 32'd1);
         end
         step(1, 0, 0, seq[i], 1, (i == 0) ? pr_last : pr);
      end
   endtask

   initial begin
      rst_n = 0;
      bus.start = 0; bus.dir = 0; bus.sin = 0; bus.sin_valid = 0; bus.pready = 0;
      m_active = 0; m_dir = 0; m_pdata = '0; m_pvalid = 0; m_overrun = 0;
      #2;

      // reset state
      step(0, 1, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0);
      check("rst_pdata",   32'(bus.pdata_out), 32'h0);
      check("rst_pvalid",  32'(bus.pvalid),    32'h0);
      check("rst_busy",    32'(bus.busy),      32'h0);
      check("rst_overrun", 32'(bus.overrun),   32'h0);

      // IDLE ignores sin_valid
      for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 1, 1);
      check("idle_no_word", 32'(bus.pvalid), 32'h0);

      // MSB-first frame
      send_frame(8'hB2, 0, 0, 1, 1);
      check("msb_word",   32'(bus.pdata_out), 32'hB2);
      check("msb_pvalid", 32'(bus.pvalid),    32'h1);
      check("msb_busy",   32'(bus.busy),      32'h0);
      idle(1, 1);
      check("msb_pvalid_one_cycle", 32'(bus.pvalid), 32'h0);
      check("msb_hold",             32'(bus.pdata_out), 32'hB2);

      // LSB-first frame, same wire bits
      send_frame(8'hB2, 1, 0, 1, 1);
      check("lsb_word", 32'(bus.pdata_out), 32'h4D);
      idle(1, 1);

      // gaps between bits
      send_frame(8'hB2, 0, 3, 1, 1);
      check("gap_word", 32'(bus.pdata_out), 32'hB2);
      idle(1, 1);

      // overrun with pready low
      send_frame(8'hB2, 0, 0, 0, 0);
      send_frame(8'hB2, 1, 0, 0, 0);
      check("ovr_word", 32'(bus.pdata_out), 32'hB2);
      check("ovr_flag", 32'(bus.overrun),   32'h1);
      idle(2, 0);
      check("ovr_sticky", 32'(bus.overrun), 32'h1);

      // reset, then consume-and-load on the same edge
      step(0, 0, 0, 0, 0, 0);
      send_frame(8'hB2, 0, 0, 0, 0);
      send_frame(8'hB2, 1, 0, 0, 1);
      check("swap_word",    32'(bus.pdata_out), 32'h4D);
      check("swap_pvalid",  32'(bus.pvalid),    32'h1);
      check("swap_overrun", 32'(bus.overrun),   32'h0);
      idle(1, 1);

      // abort after 3 bits, then a full frame
      step(1, 1, 1, 0, 0, 1);
      step(1, 0, 0, 1, 1, 1);
      step(1, 0, 0, 1, 1, 1);
      step(1, 0, 0, 0, 1, 1);
      send_frame(8'h5A, 0, 0, 1, 1);
      check("abort_word", 32'(bus.pdata_out), 32'h5A);
      idle(1, 1);
      check("abort_single", 32'(bus.pvalid), 32'h0);

      // reset mid-frame
      step(1, 1, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 1);
      step(0, 0, 0, 1, 1, 1);
      check("mid_rst_pdata",  32'(bus.pdata_out), 32'h0);
      check("mid_rst_busy",   32'(bus.busy),      32'h0);
      check("mid_rst_pvalid", 32'(bus.pvalid),    32'h0);
      idle(2, 1);
      check("mid_rst_idle", 32'(bus.busy), 32'h0);
      send_frame(8'hC3, 0, 0, 1, 1);
      check("post_rst_word", 32'(bus.pdata_out), 32'hC3);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) != 0,
              $urandom_range(0, 24) == 0,
              $urandom_range(0, 1),
              $urandom_range(0, 1),
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
